// File: rtl/mul_seq_booth4_pkg.sv
// Shared types for the sequential radix-4 Booth multiplier: FSM states,
// Booth digit codes and the step-counter width helper.
package mul_pkg;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  typedef enum logic [2:0] {
    ZERO = 3'd0,
    POS1 = 3'd1,
    POS2 = 3'd2,
    NEG1 = 3'd3,
    NEG2 = 3'd4
  } booth_digit_t;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mul_seq_booth4_recode.sv
// Radix-4 Booth recoder: maps a 3-bit multiplier window to a digit and the
// matching addend (0, +M, +2M, -M, -2M) at the accumulator width.
module booth_r4_recode
  import mul_pkg::*;
#(
  parameter int AW = 66
) (
  input  logic [2:0]    i_win,
  input  logic [AW-1:0] i_m,
  output booth_digit_t  o_digit,
  output logic [AW-1:0] o_addend
);

  always_comb begin
    o_digit = ZERO;
    unique case (i_win)
      3'b000, 3'b111: o_digit = ZERO;
      3'b001, 3'b010: o_digit = POS1;
      3'b011:         o_digit = POS2;
      3'b100:         o_digit = NEG2;
      3'b101, 3'b110: o_digit = NEG1;
      default:        o_digit = ZERO;
    endcase
  end

  always_comb begin
    o_addend = '0;
    unique case (o_digit)
      ZERO:    o_addend = '0;
      POS1:    o_addend = i_m;
      POS2:    o_addend = i_m << 1;
      NEG1:    o_addend = -i_m;
      NEG2:    o_addend = -(i_m << 1);
      default: o_addend = '0;
    endcase
  end

endmodule

// File: rtl/mul_seq_booth4.sv
// Multi-cycle radix-4 Booth multiplier: captures operands on start, retires
// two multiplier bits per clock and holds the 2*WIDTH-bit product.
module mul_seq_booth4
  import mul_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               start,
  input  logic               signed_op,
  input  logic [WIDTH-1:0]   RA,
  input  logic [WIDTH-1:0]   RB,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int ITER = WIDTH / 2 + 1;
  localparam int CW   = cnt_width(ITER);
  localparam int AW   = 2 * WIDTH + 2;
  localparam int QW   = WIDTH + 3;

  if ((WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_width
    $error("mul_seq_booth4: WIDTH must be even and at least 4");
  end

  state_t         r_state;
  logic [AW-1:0]  r_m;
  logic [AW-1:0]  r_acc;
  logic [QW-1:0]  r_q;
  logic [CW-1:0]  r_cnt;

  logic [WIDTH+1:0] w_ext_a;
  logic [WIDTH+1:0] w_ext_b;
  logic [AW-1:0]    w_addend;
  logic [AW-1:0]    w_acc_next;
  booth_digit_t     w_digit;

  // Two extra bits let the unsigned top digit be recoded like a signed one,
  // so both modes share one datapath and one latency.
  assign w_ext_a = {{2{signed_op & RA[WIDTH-1]}}, RA};
  assign w_ext_b = {{2{signed_op & RB[WIDTH-1]}}, RB};

  booth_r4_recode #(.AW(AW)) u_recode (
    .i_win    (r_q[2:0]),
    .i_m      (r_m),
    .o_digit  (w_digit),
    .o_addend (w_addend)
  );

  assign w_acc_next = (w_digit == ZERO) ? r_acc : r_acc + w_addend;

  always_ff @(posedge clock) begin
    if (clear) begin
      r_state <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      r_cnt   <= '0;
      r_m     <= '0;
      r_q     <= '0;
      r_acc   <= '0;
    end else begin
      done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_m     <= {{WIDTH{w_ext_a[WIDTH+1]}}, w_ext_a};
            r_q     <= {w_ext_b, 1'b0};
            r_acc   <= '0;
            r_cnt   <= '0;
            busy    <= 1'b1;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_acc <= w_acc_next;
          r_m   <= r_m << 2;
          r_q   <= {{2{r_q[QW-1]}}, r_q[QW-1:2]};
          r_cnt <= r_cnt + CW'(1);
          if (r_cnt == CW'(ITER - 1)) begin
            product <= w_acc_next[2*WIDTH-1:0];
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq_booth4.sv
// Self-checking bench for mul_seq_booth4 at WIDTH=32, 16 and 8 against a
// plain-arithmetic reference multiply.
module tb_mul_seq_booth4;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic        start32, so32, busy32, done32;
  logic [31:0] ra32, rb32;
  logic [63:0] prod32;

  logic        start16, so16, busy16, done16;
  logic [15:0] ra16, rb16;
  logic [31:0] prod16;

  logic        start8, so8, busy8, done8;
  logic [7:0]  ra8, rb8;
  logic [15:0] prod8;

  mul_seq_booth4 #(.WIDTH(32)) dut32 (
    .clock(clk), .clear(clr), .start(start32), .signed_op(so32),
    .RA(ra32), .RB(rb32), .busy(busy32), .done(done32), .product(prod32)
  );
  mul_seq_booth4 #(.WIDTH(16)) dut16 (
    .clock(clk), .clear(clr), .start(start16), .signed_op(so16),
    .RA(ra16), .RB(rb16), .busy(busy16), .done(done16), .product(prod16)
  );
  mul_seq_booth4 #(.WIDTH(8)) dut8 (
    .clock(clk), .clear(clr), .start(start8), .signed_op(so8),
    .RA(ra8), .RB(rb8), .busy(busy8), .done(done8), .product(prod8)
  );

  // Reference: extend each operand to 64 bits per the mode, multiply, keep 2w bits.
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic s, input int w);
    logic [63:0] ea, eb, msk, p;
    msk = (64'd1 << w) - 64'd1;
    ea = {32'd0, a} & msk;
    eb = {32'd0, b} & msk;
    if (s && ea[w-1]) ea = ea | ~msk;
    if (s && eb[w-1]) eb = eb | ~msk;
    p = ea * eb;
    if (w < 32) p = p & ((64'd1 << (2 * w)) - 64'd1);
    return p;
  endfunction

  task automatic do_op32(input logic [31:0] a, input logic [31:0] b,
                         input logic s, output int lat);
    @(negedge clk);
    start32 = 1'b1; ra32 = a; rb32 = b; so32 = s;
    @(negedge clk);
    start32 = 1'b0; ra32 = $urandom; rb32 = $urandom; so32 = 1'($urandom);
    lat = 0;
    while (done32 !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic test_reset();
    clr = 1'b1;
    start32 = 0; start16 = 0; start8 = 0;
    so32 = 0; so16 = 0; so8 = 0;
    ra32 = '0; rb32 = '0; ra16 = '0; rb16 = '0; ra8 = '0; rb8 = '0;
    repeat (3) @(negedge clk);
    clr = 1'b0;
    n_checks++;
    if (busy32 !== 1'b0 || done32 !== 1'b0 || prod32 !== 64'd0) begin
      n_fail++;
      $display("FAIL reset32: busy=%b done=%b product=%h, required 0 0 0", busy32, done32, prod32);
    end
    n_checks++;
    if (busy16 !== 1'b0 || done16 !== 1'b0 || prod16 !== 32'd0 ||
        busy8 !== 1'b0 || done8 !== 1'b0 || prod8 !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_small: busy16=%b done16=%b p16=%h busy8=%b done8=%b p8=%h, required all 0",
               busy16, done16, prod16, busy8, done8, prod8);
    end
  endtask

  task automatic test_signed_basic();
    int lat, busy_cnt;
    @(negedge clk);
    start32 = 1'b1; ra32 = 32'd7; rb32 = -32'sd3; so32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0; ra32 = '1; rb32 = '1; so32 = 1'b0;
    lat = 0; busy_cnt = 0;
    while (done32 !== 1'b1 && lat < 40) begin
      if (busy32 === 1'b1) busy_cnt++;
      @(negedge clk);
      lat++;
    end
    n_checks++;
    if (lat != 17) begin
      n_fail++;
      $display("FAIL signed_basic_latency: got %0d edges, required 17", lat);
    end
    n_checks++;
    if (prod32 !== 64'hFFFFFFFF_FFFFFFEB) begin
      n_fail++;
      $display("FAIL signed_basic_product: got %h, required ffffffffffffffeb", prod32);
    end
    n_checks++;
    if (busy_cnt != 17 || busy32 !== 1'b0) begin
      n_fail++;
      $display("FAIL signed_basic_busy: high %0d cycles, busy in done cycle=%b, required 17 and 0",
               busy_cnt, busy32);
    end
    @(negedge clk);
    n_checks++;
    if (done32 !== 1'b0) begin
      n_fail++;
      $display("FAIL signed_basic_pulse: done=%b one cycle later, required 0", done32);
    end
  endtask

  task automatic test_extremes();
    int lat;
    logic [31:0] av [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h80000000};
    logic [31:0] bv [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000, 32'h00000001};
    logic        sv [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
    logic [63:0] ev [4] = '{64'hFFFFFFFE_00000001, 64'h00000000_00000001,
                            64'h40000000_00000000, 64'hFFFFFFFF_80000000};
    for (int i = 0; i < 4; i++) begin
      do_op32(av[i], bv[i], sv[i], lat);
      n_checks++;
      if (prod32 !== ev[i] || lat != 17) begin
        n_fail++;
        $display("FAIL extreme_%0d: product=%h lat=%0d, required %h lat=17", i, prod32, lat, ev[i]);
      end
    end
  endtask

  task automatic test_busy_protect();
    int pulses;
    logic [63:0] p_at_done;
    logic busy_at_second;
    @(negedge clk);
    start32 = 1'b1; ra32 = 32'd5; rb32 = 32'd6; so32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    repeat (3) @(negedge clk);
    busy_at_second = busy32;
    start32 = 1'b1; ra32 = 32'd100; rb32 = 32'd100;
    @(negedge clk);
    start32 = 1'b0;
    pulses = 0; p_at_done = '0;
    for (int c = 0; c < 40; c++) begin
      if (done32 === 1'b1) begin
        pulses++;
        p_at_done = prod32;
      end
      @(negedge clk);
    end
    n_checks++;
    if (busy_at_second !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_protect_busy: busy=%b at second start, required 1", busy_at_second);
    end
    n_checks++;
    if (pulses != 1 || p_at_done !== 64'd30) begin
      n_fail++;
      $display("FAIL busy_protect: pulses=%0d product=%0d, required 1 and 30", pulses, p_at_done);
    end
  endtask

  task automatic test_clear_and_back_to_back();
    int pulses, lat, gap;
    @(negedge clk);
    start32 = 1'b1; ra32 = 32'd11; rb32 = 32'd13; so32 = 1'b0;
    @(negedge clk);
    start32 = 1'b0;
    repeat (7) @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    n_checks++;
    if (busy32 !== 1'b0 || prod32 !== 64'd0) begin
      n_fail++;
      $display("FAIL midop_clear: busy=%b product=%h, required 0 and 0", busy32, prod32);
    end
    pulses = 0;
    for (int c = 0; c < 25; c++) begin
      if (done32 === 1'b1) pulses++;
      @(negedge clk);
    end
    n_checks++;
    if (pulses != 0) begin
      n_fail++;
      $display("FAIL midop_clear_done: %0d done pulses, required 0", pulses);
    end
    do_op32(-32'sd2, 32'd9, 1'b1, lat);
    n_checks++;
    if (prod32 !== 64'hFFFFFFFF_FFFFFFEE || lat != 17) begin
      n_fail++;
      $display("FAIL b2b_first: product=%h lat=%0d, required ffffffffffffffee lat=17", prod32, lat);
    end
    start32 = 1'b1; ra32 = 32'd3; rb32 = 32'd4; so32 = 1'b1;
    @(negedge clk);
    start32 = 1'b0;
    gap = 0;
    while (done32 !== 1'b1 && gap < 40) begin
      @(negedge clk);
      gap++;
    end
    n_checks++;
    if (prod32 !== 64'd12 || gap != 17) begin
      n_fail++;
      $display("FAIL b2b_second: product=%0d gap=%0d, required 12 gap=17", prod32, gap);
    end
  endtask

  task automatic test_sweep16();
    int lat;
    logic [15:0] a, b;
    logic [63:0] r;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 1000; i++) begin
        a = 16'($urandom); b = 16'($urandom);
        if (i == 0) begin a = 16'h8000; b = 16'h8000; end
        if (i == 1) begin a = 16'hFFFF; b = 16'hFFFF; end
        @(negedge clk);
        start16 = 1'b1; ra16 = a; rb16 = b; so16 = 1'(s);
        @(negedge clk);
        start16 = 1'b0; ra16 = 16'($urandom); rb16 = 16'($urandom);
        lat = 0;
        while (done16 !== 1'b1 && lat < 40) begin
          @(negedge clk);
          lat++;
        end
        r = ref_mul({16'd0, a}, {16'd0, b}, 1'(s), 16);
        n_checks++;
        if (prod16 !== r[31:0] || lat != 9) begin
          n_fail++;
          $display("FAIL sweep16 s=%0d a=%h b=%h: product=%h lat=%0d, required %h lat=9",
                   s, a, b, prod16, lat, r[31:0]);
        end
      end
    end
  endtask

  task automatic test_sweep8();
    int lat;
    logic [7:0]  a, b;
    logic [63:0] r;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 1000; i++) begin
        a = 8'($urandom); b = 8'($urandom);
        if (i == 0) begin a = 8'h80; b = 8'h80; end
        if (i == 1) begin a = 8'hFF; b = 8'h80; end
        @(negedge clk);
        start8 = 1'b1; ra8 = a; rb8 = b; so8 = 1'(s);
        @(negedge clk);
        start8 = 1'b0; ra8 = 8'($urandom); rb8 = 8'($urandom);
        lat = 0;
        while (done8 !== 1'b1 && lat < 40) begin
          @(negedge clk);
          lat++;
        end
        r = ref_mul({24'd0, a}, {24'd0, b}, 1'(s), 8);
        n_checks++;
        if (prod8 !== r[15:0] || lat != 5) begin
          n_fail++;
          $display("FAIL sweep8 s=%0d a=%h b=%h: product=%h lat=%0d, required %h lat=5",
                   s, a, b, prod8, lat, r[15:0]);
        end
      end
    end
  endtask

  task automatic test_random32();
    int lat;
    logic [31:0] a, b;
    logic s;
    logic [63:0] r;
    for (int i = 0; i < 100; i++) begin
      a = $urandom; b = $urandom; s = 1'($urandom);
      do_op32(a, b, s, lat);
      r = ref_mul(a, b, s, 32);
      n_checks++;
      if (prod32 !== r || lat != 17) begin
        n_fail++;
        $display("FAIL random32 s=%0d a=%h b=%h: product=%h lat=%0d, required %h lat=17",
                 s, a, b, prod32, lat, r);
      end
    end
  endtask

  initial begin
    test_reset();
    test_signed_basic();
    test_extremes();
    test_busy_protect();
    test_clear_and_back_to_back();
    test_random32();
    test_sweep16();
    test_sweep8();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mul_seq_booth4.md
Name: mul_seq_booth4

Overview:
Multi-cycle, parametrised radix-4 Booth multiplier for the datapath's MUL instruction. It replaces the single-cycle combinational multiplier. Operands are captured on a start handshake, and the block retires 2 multiplier bits per clock. It supports signed and unsigned operation per request and holds a 2*WIDTH-bit product for the HI/LO write-back.

Parameters:
WIDTH, 32, operand width in bits; must be even and at least 4 (elaboration error otherwise)
ITER, WIDTH/2+1, derived, not overridable: number of radix-4 steps per operation

Ports:
clock  input  1  system clock, rising edge
clear  input  1  synchronous, active-high reset
start  input  1  request; sampled only when busy=0
signed_op  input  1  1 = two's-complement operands, 0 = unsigned; captured with start
RA  input  WIDTH  multiplicand; captured with start
RB  input  WIDTH  multiplier; captured with start
busy  output  1  high while an operation is in progress
done  output  1  one-cycle pulse: product valid
product  output  2*WIDTH  result; held until the next completion or clear

Behaviour:
- Reset: clear=1 at a rising edge sets state IDLE, busy=0, done=0, product=0, and step counter=0. Clear has priority over every other input. Clear during RUN aborts the operation; no done pulse follows.
- Operand extension to WIDTH+2 bits:
  - signed_op=1: sign-extend.
  - signed_op=0: zero-extend.
  - This gives a single datapath and a fixed latency for both modes.
- Internal registers:
  - M: extended multiplicand, 2*WIDTH+2 bits.
  - Q: extended multiplier plus an appended 0 LSB, WIDTH+3 bits.
  - ACC: 2*WIDTH+2 bits.
  - cnt: clog2(ITER) bits.
- States: IDLE and RUN.
  - IDLE with start=1: load M, Q, ACC=0, cnt=0; go to RUN; busy=1 from the next cycle.
  - IDLE with start=0: stay in IDLE.
  - RUN: each edge recodes Q[2:0] into digit d:
    - 000/111 -> 0
    - 001/010 -> +1
    - 011 -> +2
    - 100 -> -2
    - 101/110 -> -1
  - RUN update per edge: ACC += d*M (the weight is applied by the shift of M); M <<= 2; Q >>>= 2 (arithmetic); cnt++.
  - RUN exit: on the edge where cnt==ITER-1, write product = the low 2*WIDTH bits of the final ACC, pulse done=1 for one cycle, set busy=0, and return to IDLE.
- Latency: if start is sampled at edge E0, done is high in the cycle following edge E(ITER). For WIDTH=32 that is 17 edges.
- Throughput: start may be asserted during the done cycle. It is accepted, giving back-to-back operations with no idle gap.
- start while busy=1: ignored. Captured operands are unaffected, and no queueing occurs.
- Inputs RA, RB and signed_op may change freely after the start edge.
- product changes only at the completion edge or on clear. It is not cleared when a new operation starts.
- Arithmetic: all sums are truncated modulo 2^(2*WIDTH+2), with no overflow flag. The result is exact for all inputs in both modes, including the most negative operand.

Decomposition:
- Package mul_pkg:
  - State enum {IDLE, RUN}.
  - Booth digit encoding constants (ZERO, POS1, POS2, NEG1, NEG2).
  - Function clog2-based counter-width helper.
- Sub-module booth_r4_recode:
  - Purely combinational.
  - Maps the 3-bit window to a digit code.
  - Produces the selected addend: 0, M, 2M, -M or -2M, at 2*WIDTH+2 bits.
- The top level holds the FSM, counter and registers.

Test Plan:
1. Signed basic: WIDTH=32, signed_op=1, RA=7, RB=-3 -> done exactly 17 edges after start; product=0xFFFFFFFF_FFFFFFEB; busy high for 17 cycles, low in the done cycle.
2. Unsigned max: signed_op=0, RA=RB=0xFFFFFFFF -> product=0xFFFFFFFE_00000001. With signed_op=1 and the same operands -> product=0x00000000_00000001.
3. Most negative: signed_op=1, RA=RB=0x80000000 -> product=0x40000000_00000000. Also RA=0x80000000, RB=1 -> product=0xFFFFFFFF_80000000.
4. Busy protection: start with RA=5, RB=6; at cycle 4, start with RA=100, RB=100 -> second start ignored; single done pulse; product=30.
5. Mid-op clear plus back-to-back:
   - clear at cycle 8 of an operation -> busy=0, product=0, no done pulse.
   - Then start (RA=-2, RB=9) held high in its done cycle with new operands (RA=3, RB=4) -> products -18 then 12, with done pulses 17 cycles apart.
6. Parameter sweep: WIDTH=8 and 16, with 1000 random operand pairs per mode -> every result matches the reference multiply; latency is WIDTH/2+1.
